// File: rtl/glitch_sweep_ctrl.sv
// Sweep sequencer for fault injection: steps trigger_delay through a range of
// delay points, forwards one target trigger per attempt and tallies the results.
module glitch_sweep_ctrl #(
  parameter int DELAY_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DELAY_W-1:0] delay_start,
  input  logic [DELAY_W-1:0] delay_end,
  input  logic [DELAY_W-1:0] delay_step,
  input  logic [CNT_W-1:0]   repeats,
  input  logic [CNT_W-1:0]   settle_cycles,
  input  logic [DELAY_W-1:0] timeout_cycles,
  input  logic               trig_in,
  input  logic               delayed_trigger,
  output logic               trig_out,
  output logic [DELAY_W-1:0] delay,
  output logic               set_delay,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               attempt_done,
  output logic               attempt_fired,
  output logic [DELAY_W-1:0] cur_delay,
  output logic [31:0]        attempts,
  output logic [31:0]        timeouts
);

  localparam logic [DELAY_W-1:0] D_ZERO = DELAY_W'(0);
  localparam logic [DELAY_W-1:0] D_ONE  = DELAY_W'(1);
  localparam logic [CNT_W-1:0]   C_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]   C_ONE  = CNT_W'(1);
  localparam logic [31:0]        SAT32  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_LOAD   = 3'd2,
    S_ARM    = 3'd3,
    S_FIRE   = 3'd4,
    S_SETTLE = 3'd5,
    S_NEXT   = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] end_q, end_d, step_q, step_d, timeout_q, timeout_d;
  logic [DELAY_W-1:0] cur_delay_q, cur_delay_d, tmo_cnt_q, tmo_cnt_d, delay_q, delay_d;
  logic [CNT_W-1:0]   repeats_q, repeats_d, settle_q, settle_d;
  logic [CNT_W-1:0]   rep_cnt_q, rep_cnt_d, settle_cnt_q, settle_cnt_d;
  logic [31:0]        attempts_q, attempts_d, timeouts_q, timeouts_d;
  logic               set_delay_q, set_delay_d, busy_q, busy_d, done_q, done_d;
  logic               err_q, err_d, attempt_done_q, attempt_done_d;
  logic               attempt_fired_q, attempt_fired_d;

  logic [CNT_W-1:0]   rep_max_s, settle_max_s;
  logic [CNT_W:0]     rep_next_s, settle_next_s;
  logic [DELAY_W:0]   sum_s;
  logic [DELAY_W-1:0] tmo_next_s;

  // Zero counts mean "once"; the extra sum bit catches wrap past the top of the range.
  assign rep_max_s     = (repeats_q == C_ZERO) ? C_ONE : repeats_q;
  assign settle_max_s  = (settle_q == C_ZERO) ? C_ONE : settle_q;
  assign rep_next_s    = {1'b0, rep_cnt_q} + {C_ZERO, 1'b1};
  assign settle_next_s = {1'b0, settle_cnt_q} + {C_ZERO, 1'b1};
  assign sum_s         = {1'b0, cur_delay_q} + {1'b0, step_q};
  assign tmo_next_s    = tmo_cnt_q + D_ONE;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      end_q           <= D_ZERO;
      step_q          <= D_ZERO;
      timeout_q       <= D_ZERO;
      cur_delay_q     <= D_ZERO;
      tmo_cnt_q       <= D_ZERO;
      delay_q         <= D_ZERO;
      repeats_q       <= C_ZERO;
      settle_q        <= C_ZERO;
      rep_cnt_q       <= C_ZERO;
      settle_cnt_q    <= C_ZERO;
      attempts_q      <= 32'd0;
      timeouts_q      <= 32'd0;
      set_delay_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      attempt_done_q  <= 1'b0;
      attempt_fired_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      end_q           <= end_d;
      step_q          <= step_d;
      timeout_q       <= timeout_d;
      cur_delay_q     <= cur_delay_d;
      tmo_cnt_q       <= tmo_cnt_d;
      delay_q         <= delay_d;
      repeats_q       <= repeats_d;
      settle_q        <= settle_d;
      rep_cnt_q       <= rep_cnt_d;
      settle_cnt_q    <= settle_cnt_d;
      attempts_q      <= attempts_d;
      timeouts_q      <= timeouts_d;
      set_delay_q     <= set_delay_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
      attempt_done_q  <= attempt_done_d;
      attempt_fired_q <= attempt_fired_d;
    end
  end

  // Next-state and registered-output logic; abort overrides every transition
  always_comb begin
    state_d         = state_q;
    end_d           = end_q;
    step_d          = step_q;
    timeout_d       = timeout_q;
    cur_delay_d     = cur_delay_q;
    tmo_cnt_d       = tmo_cnt_q;
    repeats_d       = repeats_q;
    settle_d        = settle_q;
    rep_cnt_d       = rep_cnt_q;
    settle_cnt_d    = settle_cnt_q;
    attempts_d      = attempts_q;
    timeouts_d      = timeouts_q;
    done_d          = 1'b0;
    err_d           = 1'b0;
    attempt_done_d  = 1'b0;
    attempt_fired_d = attempt_fired_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            end_d       = delay_end;
            step_d      = delay_step;
            timeout_d   = timeout_cycles;
            repeats_d   = repeats;
            settle_d    = settle_cycles;
            cur_delay_d = delay_start;
            rep_cnt_d   = C_ZERO;
            attempts_d  = 32'd0;
            timeouts_d  = 32'd0;
            state_d     = S_CHECK;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CHECK: begin
          if ((step_q == D_ZERO) || (cur_delay_q > end_q)) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          tmo_cnt_d = D_ZERO;
          state_d   = S_ARM;
        end
        S_ARM: begin
          if (delayed_trigger) begin
            state_d = S_FIRE;
          end else if ((timeout_q != D_ZERO) && (tmo_next_s == timeout_q)) begin
            attempt_done_d  = 1'b1;
            attempt_fired_d = 1'b0;
            timeouts_d      = (timeouts_q == SAT32) ? timeouts_q : timeouts_q + 32'd1;
            settle_cnt_d    = C_ZERO;
            state_d         = S_SETTLE;
          end else begin
            tmo_cnt_d = tmo_next_s;
            state_d   = S_ARM;
          end
        end
        S_FIRE: begin
          if (!delayed_trigger) begin
            attempt_done_d  = 1'b1;
            attempt_fired_d = 1'b1;
            settle_cnt_d    = C_ZERO;
            state_d         = S_SETTLE;
          end else begin
            state_d = S_FIRE;
          end
        end
        S_SETTLE: begin
          if (settle_next_s >= {1'b0, settle_max_s}) begin
            state_d = S_NEXT;
          end else begin
            settle_cnt_d = settle_next_s[CNT_W-1:0];
            state_d      = S_SETTLE;
          end
        end
        S_NEXT: begin
          attempts_d = (attempts_q == SAT32) ? attempts_q : attempts_q + 32'd1;
          if (rep_next_s < {1'b0, rep_max_s}) begin
            rep_cnt_d = rep_next_s[CNT_W-1:0];
            state_d   = S_LOAD;
          end else begin
            rep_cnt_d = C_ZERO;
            if (sum_s[DELAY_W] || (sum_s[DELAY_W-1:0] > end_q)) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              cur_delay_d = sum_s[DELAY_W-1:0];
              state_d     = S_LOAD;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    set_delay_d = (state_d == S_LOAD);
    delay_d     = set_delay_d ? cur_delay_d : delay_q;
    busy_d      = (state_d != S_IDLE);
  end

  // Only the trigger path is combinational, so delay precision is not lost.
  assign trig_out      = trig_in && (state_q == S_ARM) && !abort;
  assign delay         = delay_q;
  assign set_delay     = set_delay_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign attempt_done  = attempt_done_q;
  assign attempt_fired = attempt_fired_q;
  assign cur_delay     = cur_delay_q;
  assign attempts      = attempts_q;
  assign timeouts      = timeouts_q;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Self-checking bench for glitch_sweep_ctrl: directed and randomized sweeps
// against a list-based model of which delay points get attempted.
module tb_glitch_sweep_ctrl;

  logic        clk, rst, start, abort;
  logic [31:0] delay_start, delay_end, delay_step, timeout_cycles;
  logic [15:0] repeats, settle_cycles;
  logic        trig_in, delayed_trigger;
  logic        trig_out, set_delay, busy, done, err, attempt_done, attempt_fired;
  logic [31:0] delay, cur_delay, attempts, timeouts;

  int total = 0;
  int bad   = 0;

  int fire_en   = 0;
  int trig_mode = 0;
  int fire_dly  = 5;
  int fire_w    = 3;

  int          cyc = 0;
  int          last_set_cyc = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic        busy_at_done = 1'b0;
  logic [31:0] obs_delays[$];
  logic        obs_fired[$];
  int          obs_lat[$];

  glitch_sweep_ctrl #(.DELAY_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .delay_start(delay_start), .delay_end(delay_end), .delay_step(delay_step),
    .repeats(repeats), .settle_cycles(settle_cycles), .timeout_cycles(timeout_cycles),
    .trig_in(trig_in), .delayed_trigger(delayed_trigger), .trig_out(trig_out),
    .delay(delay), .set_delay(set_delay), .busy(busy), .done(done), .err(err),
    .attempt_done(attempt_done), .attempt_fired(attempt_fired), .cur_delay(cur_delay),
    .attempts(attempts), .timeouts(timeouts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Environment: raw trigger source and a trigger_delay stand-in that fires
  // fire_dly cycles after each trig_out rise and holds high fire_w cycles.
  initial begin : trig_model
    int   pend;
    int   hold;
    logic prev_tout;
    logic rise;
    pend = 0;
    hold = 0;
    prev_tout = 1'b0;
    forever begin
      @(negedge clk);
      rise = trig_out && !prev_tout;
      prev_tout = trig_out;
      if (fire_en == 0) begin
        pend = 0;
        hold = 0;
        delayed_trigger = 1'b0;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) delayed_trigger = 1'b0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          delayed_trigger = 1'b1;
          hold = fire_w;
        end
      end else if (rise) begin
        pend = fire_dly;
      end
      case (trig_mode)
        1:       trig_in = ($urandom_range(0, 3) == 0);
        2:       trig_in = 1'b1;
        default: trig_in = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (set_delay) begin
          obs_delays.push_back(delay);
          last_set_cyc = cyc;
        end
        if (attempt_done) begin
          obs_fired.push_back(attempt_fired);
          obs_lat.push_back(cyc - last_set_cyc);
        end
        if (done) begin
          done_cnt++;
          busy_at_done = busy;
        end
        if (err) err_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_flags"}, 64'({busy, done, err, set_delay, attempt_done, attempt_fired, trig_out}), 64'd0);
    chk({tag, "_delay"}, 64'(delay), 64'd0);
    chk({tag, "_cur_delay"}, 64'(cur_delay), 64'd0);
    chk({tag, "_attempts"}, 64'(attempts), 64'd0);
    chk({tag, "_timeouts"}, 64'(timeouts), 64'd0);
  endtask

  task automatic begin_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                             input logic [15:0] rp, input logic [15:0] sc, input logic [31:0] tmo);
    delay_start = s; delay_end = e; delay_step = st;
    repeats = rp; settle_cycles = sc; timeout_cycles = tmo;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Full sweep with its expectation built from the range arithmetic alone.
  task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                           input logic [15:0] rp, input logic [15:0] sc, input logic [31:0] tmo,
                           input bit exp_timeout);
    logic [31:0]     exp_pts[$];
    bit              is_err;
    bit              ok;
    int              nr;
    longint unsigned d;
    is_err = (st == 32'd0) || (s > e);
    nr = (rp == 16'd0) ? 1 : int'(rp);
    if (!is_err) begin
      d = longint'(s);
      while (d <= longint'(e)) begin
        for (int r = 0; r < nr; r++) exp_pts.push_back(d[31:0]);
        d += longint'(st);
      end
    end
    obs_delays.delete(); obs_fired.delete(); obs_lat.delete();
    done_cnt = 0; err_cnt = 0; busy_at_done = 1'b1;
    begin_sweep(s, e, st, rp, sc, tmo);
    // config changes after acceptance must be ignored
    delay_start = $urandom; delay_end = $urandom; delay_step = $urandom;
    repeats = 16'($urandom); settle_cycles = 16'($urandom); timeout_cycles = $urandom;
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'd1);
    @(negedge clk);
    if (is_err) chk("err_done_timing", 64'({done, err, busy}), 64'b110);
    else        chk("first_load", 64'({set_delay, delay}), {31'd0, 1'b1, s});
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #2;
      if (done_cnt != 0) begin ok = 1'b1; break; end
    end
    chk("sweep_finished", 64'(ok), 64'd1);
    repeat (2) begin @(posedge clk); #2; end
    chk("n_points", 64'(obs_delays.size()), 64'(exp_pts.size()));
    for (int i = 0; i < exp_pts.size() && i < obs_delays.size(); i++)
      chk("point", 64'(obs_delays[i]), 64'(exp_pts[i]));
    chk("n_attempt_done", 64'(obs_fired.size()), 64'(exp_pts.size()));
    for (int i = 0; i < obs_fired.size(); i++) begin
      chk("fired", 64'(obs_fired[i]), 64'(!exp_timeout));
      if (exp_timeout) chk("timeout_latency", 64'(obs_lat[i]), 64'(tmo) + 64'd1);
    end
    chk("attempts", 64'(attempts), 64'(exp_pts.size()));
    chk("timeouts", 64'(timeouts), exp_timeout ? 64'(exp_pts.size()) : 64'd0);
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("err_count", 64'(err_cnt), 64'(is_err));
    chk("busy_at_done", 64'(busy_at_done), 64'd0);
    if (is_err) chk("cur_delay_end", 64'(cur_delay), 64'(s));
    else        chk("cur_delay_end", 64'(cur_delay), 64'(exp_pts[exp_pts.size()-1]));
  endtask

  initial begin : main
    int   rises;
    logic prev_dt;
    bit   ok;
    logic [31:0] rs, re, rst_step, rtmo;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    delay_start = 32'd0; delay_end = 32'd0; delay_step = 32'd0;
    repeats = 16'd0; settle_cycles = 16'd0; timeout_cycles = 32'd0;
    trig_in = 1'b0; delayed_trigger = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk); #2;

    // nominal sweep with a firing target
    fire_en = 1; fire_dly = 5; fire_w = 3; trig_mode = 2;
    run_sweep(32'd0, 32'd20, 32'd10, 16'd2, 16'd4, 32'd0, 1'b0);
    // invalid configurations
    run_sweep(32'd0, 32'd20, 32'd0, 16'd1, 16'd1, 32'd0, 1'b0);
    run_sweep(32'd5, 32'd3, 32'd1, 16'd1, 16'd1, 32'd0, 1'b0);
    // carry-out ends the sweep after a single point
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 16'd1, 32'd0, 1'b0);
    // silent target: every attempt times out, sweep still advances
    fire_en = 0; trig_mode = 1;
    run_sweep(32'd3, 32'd7, 32'd2, 16'd1, 16'd2, 32'd8, 1'b1);

    // abort during the second FIRE
    fire_en = 1; fire_dly = 3; fire_w = 20; trig_mode = 2;
    begin_sweep(32'd4, 32'd4, 32'd1, 16'd3, 16'd2, 32'd0);
    rises = 0; prev_dt = 1'b0; ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      if (delayed_trigger && !prev_dt) rises++;
      prev_dt = delayed_trigger;
      if (rises == 2) begin ok = 1'b1; break; end
    end
    chk("abort_reach_fire", 64'(ok), 64'd1);
    done_cnt = 0;
    abort = 1'b1;
    #1;
    chk("abort_fire_trig_out", 64'(trig_out), 64'd0);
    @(posedge clk); #2;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_attempts_kept", 64'(attempts), 64'd1);
    repeat (5) begin @(posedge clk); #2; end
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    fire_en = 0;
    repeat (3) begin @(posedge clk); #2; end
    fire_en = 1; fire_dly = 5; fire_w = 3;
    run_sweep(32'd1, 32'd5, 32'd2, 16'd1, 16'd1, 32'd0, 1'b0);

    // randomized sweeps
    for (int it = 0; it < 6; it++) begin
      rs = 32'($urandom_range(0, 30));
      re = rs + 32'($urandom_range(0, 40));
      rst_step = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) begin
        fire_en = 1; trig_mode = 1; fire_dly = $urandom_range(1, 6); fire_w = $urandom_range(1, 4);
        run_sweep(rs, re, rst_step, 16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)), 32'd0, 1'b0);
      end else begin
        fire_en = 0; trig_mode = 1;
        rtmo = 32'($urandom_range(1, 10));
        run_sweep(rs, re, rst_step, 16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)), rtmo, 1'b1);
      end
    end

    // abort while ARM forwards a high trigger: trig_out must drop at once
    fire_en = 0; trig_mode = 2;
    begin_sweep(32'd7, 32'd9, 32'd1, 16'd1, 16'd1, 32'd0);
    repeat (5) begin @(posedge clk); #2; end
    chk("arm_trig_out", 64'(trig_out), 64'd1);
    abort = 1'b1;
    #1;
    chk("abort_arm_trig_out", 64'(trig_out), 64'd0);
    @(posedge clk); #2;
    abort = 1'b0;
    chk("abort_arm_busy", 64'(busy), 64'd0);

    // asynchronous reset in the middle of ARM
    begin_sweep(32'd7, 32'd9, 32'd1, 16'd1, 16'd1, 32'd0);
    repeat (5) begin @(posedge clk); #2; end
    chk("arm_trig_out_2", 64'(trig_out), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk_reset_state("async_reset");
    @(posedge clk); #2;
    rst = 1'b0;
    trig_mode = 0;
    @(negedge clk);
    chk("post_reset_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
